// File: rtl/ttseq_pkg.sv
// ----------------------------------------------------------------------------
// ttseq_pkg
// Shared definitions for the truth-table sequencer: controller state
// encoding, table geometry, default parameter values and the signature
// fold step.
// Optional feature macro used by the sequencer: TTSEQ_SIGNATURE_EN.
// ----------------------------------------------------------------------------
package ttseq_pkg;

    localparam int ROWS              = 16;
    localparam int ROW_W             = 4;
    localparam int SIG_W             = 16;
    localparam int DEF_NUM_OUT       = 10;
    localparam int DEF_SETTLE_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // One signature step: rotate left by one, then fold in the captured row.
    function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] s,
                                                  input logic [SIG_W-1:0] f);
        return {s[SIG_W-2:0], s[SIG_W-1]} ^ f;
    endfunction

endpackage

// File: rtl/ttseq_result_buf.sv
// ----------------------------------------------------------------------------
// ttseq_result_buf
// 16 x NUM_OUT result storage for the truth-table sequencer, one write port
// and one registered read port. A read and a write to the same entry in the
// same cycle return the old contents.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset, clears every entry and rd_data
//   wr_en    in   write strobe
//   wr_addr  in   4-bit write address
//   wr_data  in   NUM_OUT write data
//   rd_addr  in   4-bit read address
//   rd_data  out  NUM_OUT registered read data
// ----------------------------------------------------------------------------
module ttseq_result_buf
    import ttseq_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ROW_W-1:0]   wr_addr,
    input  logic [NUM_OUT-1:0] wr_data,
    input  logic [ROW_W-1:0]   rd_addr,
    output logic [NUM_OUT-1:0] rd_data
);

    logic [NUM_OUT-1:0] mem_q [ROWS];
    logic [NUM_OUT-1:0] rd_data_q;

    // Flop-based storage: every entry must clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer
// Sweeps the 16 rows of a 4-input combinational function block: drives each
// row on w/x/y/z, waits SETTLE_CYCLES, captures the NUM_OUT function outputs
// into a result buffer, and pulses done after row 15. An optional 16-bit
// signature of the captured rows is enabled by defining TTSEQ_SIGNATURE_EN.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   start    in   begin a sweep (accepted only in IDLE)
//   abort    in   terminate a sweep in progress, no done pulse
//   w,x,y,z  out  stimulus bits, w = row[3], z = row[0]
//   f        in   NUM_OUT function-block outputs
//   busy     out  high in DRIVE, SETTLE, CAPTURE
//   done     out  one-cycle completion pulse
//   row      out  row currently driven
//   rd_addr  in   result-buffer read address
//   rd_data  out  registered result-buffer data
//   sig      out  16-bit signature (only with TTSEQ_SIGNATURE_EN)
// ----------------------------------------------------------------------------
module truth_table_sequencer
    import ttseq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NUM_OUT       = DEF_NUM_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               w,
    output logic               x,
    output logic               y,
    output logic               z,
    input  logic [NUM_OUT-1:0] f,
    output logic               busy,
    output logic               done,
    output logic [ROW_W-1:0]   row,
    input  logic [ROW_W-1:0]   rd_addr,
`ifdef TTSEQ_SIGNATURE_EN
    output logic [SIG_W-1:0]   sig,
`endif
    output logic [NUM_OUT-1:0] rd_data
);

    localparam logic [ROW_W-1:0] SETTLE_LD = ROW_W'(SETTLE_CYCLES);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic             cap_en;
    logic             busy_w;

    assign busy_w = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                    (state_q == ST_CAPTURE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                row_d = '0;
                if (start) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = SETTLE_LD;
                state_d = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // Counter was loaded with SETTLE_CYCLES, so leaving at 1
                // gives exactly SETTLE_CYCLES cycles in this state.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cap_en = 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every other transition, including a pending capture.
        if (abort && busy_w) begin
            state_d = ST_IDLE;
            row_d   = '0;
            cap_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_w;
    assign done = (state_q == ST_DONE);
    assign row  = row_q;
    assign w    = busy_w & row_q[3];
    assign x    = busy_w & row_q[2];
    assign y    = busy_w & row_q[1];
    assign z    = busy_w & row_q[0];

    ttseq_result_buf #(
        .NUM_OUT (NUM_OUT)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cap_en),
        .wr_addr (row_q),
        .wr_data (f),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef TTSEQ_SIGNATURE_EN
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if ((state_q == ST_IDLE) && start) begin
            sig_d = '0;
        end else if (cap_en) begin
            sig_d = sig_fold(sig_q, SIG_W'(f));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic       wa, xa, ya, za, wb, xb, yb, zb;
    logic [9:0] fa, fb;
    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] row_a, row_b, rd_addr_a, rd_addr_b;
    logic [9:0] rd_data_a, rd_data_b;
`ifdef TTSEQ_SIGNATURE_EN
    logic [15:0] sig_a, sig_b;
`endif

    logic [7:0] hi_tab [16];
    int checks = 0;
    int errors = 0;

    // Function block under test: f0, f1 from the bench model, upper bits
    // taken from a per-row random table so each row has a distinct pattern.
    always_comb begin
        fa[0]   = (wa | ya) & (za | xa);
        fa[1]   = (!wa & xa & za) | (ya & za) | (wa & xa);
        fa[9:2] = hi_tab[{wa, xa, ya, za}];
    end
    always_comb begin
        fb[0]   = (wb | yb) & (zb | xb);
        fb[1]   = (!wb & xb & zb) | (yb & zb) | (wb & xb);
        fb[9:2] = hi_tab[{wb, xb, yb, zb}];
    end

    truth_table_sequencer #(.SETTLE_CYCLES(3), .NUM_OUT(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .w(wa), .x(xa), .y(ya), .z(za), .f(fa),
        .busy(busy_a), .done(done_a), .row(row_a),
        .rd_addr(rd_addr_a),
`ifdef TTSEQ_SIGNATURE_EN
        .sig(sig_a),
`endif
        .rd_data(rd_data_a)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(0), .NUM_OUT(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .w(wb), .x(xb), .y(yb), .z(zb), .f(fb),
        .busy(busy_b), .done(done_b), .row(row_b),
        .rd_addr(rd_addr_b),
`ifdef TTSEQ_SIGNATURE_EN
        .sig(sig_b),
`endif
        .rd_data(rd_data_b)
    );

    // Reference: expected captured value for a row index.
    function automatic logic [9:0] fmodel(input int r, input logic [7:0] hi);
        logic w, x, y, z;
        w = r[3]; x = r[2]; y = r[1]; z = r[0];
        return {hi, (!w & x & z) | (y & z) | (w & x), (w | y) & (z | x)};
    endfunction

    function automatic logic [15:0] sig_model(input int nrows);
        logic [15:0] s;
        s = '0;
        for (int r = 0; r < nrows; r++)
            s = {s[14:0], s[15]} ^ {6'b0, fmodel(r, hi_tab[r])};
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_table(input bit rnd);
        for (int r = 0; r < 16; r++) hi_tab[r] = rnd ? 8'($urandom) : 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b1; abort_a = 1'b1; start_b = 1'b1;
        step();
        checks++;
        if ({busy_a, done_a, row_a, wa, xa, ya, za} !== 10'b0 || rd_data_a !== 10'h0) begin
            errors++;
            $display("FAIL reset_a: busy=%b done=%b row=%0d wxyz=%b rd=%h, want all 0",
                     busy_a, done_a, row_a, {wa, xa, ya, za}, rd_data_a);
        end
        checks++;
        if ({busy_b, done_b, row_b, wb, xb, yb, zb} !== 10'b0 || rd_data_b !== 10'h0) begin
            errors++;
            $display("FAIL reset_b: busy=%b done=%b row=%0d rd=%h, want all 0",
                     busy_b, done_b, row_b, rd_data_b);
        end
        rst_n = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0;
        step();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy_a=%b busy_b=%b, want 0", busy_a, busy_b);
        end
    endtask

    task automatic test_sweep(input bit rnd);
        int lat, poke, ofs;
        int addrs [4];
        logic [9:0] fixed [4];
        addrs = '{0, 3, 8, 12};
        fixed = '{10'h000, 10'h003, 10'h000, 10'h003};
        randomize_table(rnd);
        poke = $urandom_range(10, 70);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL sweep_busy_rise: busy=%b, want 1", busy_a);
        end
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done_a === 1'b1) begin
                lat = k;
                break;
            end
            if (k < 80) begin
                checks++;
                if (busy_a !== 1'b1 || row_a !== 4'(k / 5) || {wa, xa, ya, za} !== 4'(k / 5)) begin
                    errors++;
                    $display("FAIL sweep_drive k=%0d: busy=%b row=%0d wxyz=%b, want busy=1 row=%0d",
                             k, busy_a, row_a, {wa, xa, ya, za}, k / 5);
                end
            end
            start_a = (k == poke);
            step();
        end
        start_a = 1'b0;
        checks++;
        if (lat != 80) begin
            errors++;
            $display("FAIL sweep_latency: done after %0d edges, want 80", lat);
        end
`ifdef TTSEQ_SIGNATURE_EN
        checks++;
        if (sig_a !== sig_model(16)) begin
            errors++;
            $display("FAIL sweep_sig: got %h, want %h", sig_a, sig_model(16));
        end
`endif
        // A start presented while in DONE must be ignored.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || {wa, xa, ya, za} !== 4'b0) begin
            errors++;
            $display("FAIL sweep_after_done: done=%b busy=%b wxyz=%b, want 0",
                     done_a, busy_a, {wa, xa, ya, za});
        end
        step();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b, want 0", busy_a);
        end
`ifdef TTSEQ_SIGNATURE_EN
        checks++;
        if (sig_a !== sig_model(16)) begin
            errors++;
            $display("FAIL sig_hold: got %h, want %h", sig_a, sig_model(16));
        end
`endif
        if (!rnd) begin
            for (int i = 0; i < 4; i++) begin
                rd_addr_a = 4'(addrs[i]);
                step();
                checks++;
                if (rd_data_a !== fixed[i]) begin
                    errors++;
                    $display("FAIL read_fixed addr=%0d: got %h, want %h", addrs[i], rd_data_a, fixed[i]);
                end
            end
        end
        ofs = $urandom_range(0, 15);
        for (int i = 0; i < 16; i++) begin
            int a;
            a = (i * 7 + ofs) % 16;
            rd_addr_a = 4'(a);
            step();
            checks++;
            if (rd_data_a !== fmodel(a, hi_tab[a])) begin
                errors++;
                $display("FAIL read_sweep addr=%0d: got %h, want %h", a, rd_data_a, fmodel(a, hi_tab[a]));
            end
        end
    endtask

    task automatic test_settle0();
        int lat;
        randomize_table(1'b1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done_b === 1'b1) begin
                lat = k;
                break;
            end
            if (k < 32) begin
                checks++;
                if (busy_b !== 1'b1 || row_b !== 4'(k / 2) || {wb, xb, yb, zb} !== 4'(k / 2)) begin
                    errors++;
                    $display("FAIL settle0_drive k=%0d: busy=%b row=%0d, want row=%0d", k, busy_b, row_b, k / 2);
                end
            end
            step();
        end
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL settle0_latency: done after %0d edges, want 32", lat);
        end
        step();
        for (int a = 0; a < 16; a++) begin
            rd_addr_b = 4'(a);
            step();
            checks++;
            if (rd_data_b !== fmodel(a, hi_tab[a])) begin
                errors++;
                $display("FAIL settle0_read addr=%0d: got %h, want %h", a, rd_data_b, fmodel(a, hi_tab[a]));
            end
        end
    endtask

    task automatic test_abort();
        int off;
        bit saw_done;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        randomize_table(1'b1);
        // Abort in IDLE has no effect.
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b, want 0", busy_a, done_a);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        off = $urandom_range(1, 3);
        for (int k = 0; k < 25 + off; k++) step();
        checks++;
        if (row_a !== 4'd5 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: row=%0d busy=%b, want row=5 busy=1", row_a, busy_a);
        end
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || row_a !== 4'd0 || {wa, xa, ya, za} !== 4'b0) begin
            errors++;
            $display("FAIL abort_idle_next: busy=%b done=%b row=%0d, want 0 0 0", busy_a, done_a, row_a);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: activity seen after abort, want none");
        end
        for (int a = 0; a < 16; a++) begin
            logic [9:0] exp;
            exp = (a < 5) ? fmodel(a, hi_tab[a]) : 10'h000;
            rd_addr_a = 4'(a);
            step();
            checks++;
            if (rd_data_a !== exp) begin
                errors++;
                $display("FAIL abort_read addr=%0d: got %h, want %h", a, rd_data_a, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        randomize_table(1'b1);
        rd_addr_a = 4'd3;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 49; k++) step();
        checks++;
        if (row_a !== 4'd9 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: row=%0d busy=%b, want row=9 busy=1", row_a, busy_a);
        end
        rst_n = 1'b0; start_a = 1'b1; abort_a = 1'b1;
        step();
        checks++;
        if ({busy_a, done_a, row_a, wa, xa, ya, za} !== 10'b0 || rd_data_a !== 10'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: busy=%b done=%b row=%0d rd=%h, want 0",
                     busy_a, done_a, row_a, rd_data_a);
        end
`ifdef TTSEQ_SIGNATURE_EN
        checks++;
        if (sig_a !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_sig: got %h, want 0", sig_a);
        end
`endif
        rst_n = 1'b1; start_a = 1'b0; abort_a = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            step();
            checks++;
            if (rd_data_a !== 10'h0) begin
                errors++;
                $display("FAIL rstmid_buf addr=%0d: got %h, want 0", a, rd_data_a);
            end
        end
        randomize_table(1'b1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done_a === 1'b1) begin
                lat = k;
                break;
            end
            step();
        end
        checks++;
        if (lat != 80) begin
            errors++;
            $display("FAIL rstmid_restart_latency: %0d edges, want 80", lat);
        end
        step();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            step();
            checks++;
            if (rd_data_a !== fmodel(a, hi_tab[a])) begin
                errors++;
                $display("FAIL rstmid_read addr=%0d: got %h, want %h", a, rd_data_a, fmodel(a, hi_tab[a]));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        for (int r = 0; r < 16; r++) hi_tab[r] = 8'h00;
        step();
        step();
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_settle0();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
